// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial add/subtract controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/sa_bit_cell.sv
// One-bit full-adder slice, time-shared across all operand bits by the controller.
module sa_bit_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  logic p;

  assign p      = a_i ^ b_i;
  assign s_o    = p ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & p);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one bit per clock, LSB first, through a single
// full-adder slice. Handshakes: a transfer happens on a rising edge where valid && ready.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_ovf
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cmsb_q, cmsb_d;
  logic             bit_s, bit_co;

  sa_bit_cell u_cell (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .cin_i  (carry_q),
    .s_o    (bit_s),
    .cout_o (bit_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cmsb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cmsb_q  <= cmsb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cmsb_d  = cmsb_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          // Subtract is A + ~B + 1: invert B here and seed the carry with 1.
          a_d     = in_a;
          b_d     = (in_sub == OP_SUB) ? ~in_b : in_b;
          carry_d = (in_sub == OP_SUB);
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = {bit_s, sum_q[WIDTH-1:1]};
        carry_d = bit_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cmsb_d  = carry_q;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Gating with rst_n keeps in_ready low for the whole time reset is held.
  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sum   = sum_q;
  assign out_carry = carry_q;
  assign out_ovf   = cmsb_q ^ carry_q;

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial add/subtract controller that time-shares a single one-bit full-adder slice across all bits of a WIDTH-bit operand pair. It accepts operands over a valid/ready handshake and processes one bit per clock, LSB first. It returns sum, carry-out and signed-overflow over a second valid/ready handshake. It is the sequencing front end for the adder datapath, where area matters more than latency.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..64
CNT_W, $clog2(WIDTH), bit-counter width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands/op valid
in_ready  output  1  controller can accept a new operation
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_sub  input  1  0 = A+B, 1 = A-B
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_sum  output  WIDTH  result bits
out_carry  output  1  final carry-out (for subtract: 1 = no borrow)
out_ovf  output  1  two's-complement overflow

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (asynchronous, rst_n=0): state=IDLE; in_ready=1 once reset is released; out_valid=0; out_sum=0; out_carry=0; out_ovf=0; counter=0; carry flop=0.
- IDLE: in_ready=1. On in_valid&&in_ready at a clock edge:
  - load shift_a=in_a and shift_b = in_sub ? ~in_b : in_b
  - carry flop = in_sub; counter=0; go to RUN.
- RUN: in_ready=0.
  - Each cycle the bit slice computes s, co from (shift_a[0], shift_b[0], carry).
  - On the edge: s shifts into the MSB of the sum register (right shift); shift_a and shift_b shift right; carry <= co; counter++.
  - When counter==WIDTH-1, also capture carry-into-MSB (the carry value before the update), then go to DONE.
- DONE: out_valid=1. out_sum = full sum register; out_carry = final carry; out_ovf = carry_into_MSB XOR out_carry.
  - Outputs stay stable while out_valid=1 && out_ready=0.
  - On out_ready, go to IDLE. A new operation cannot be accepted in that same cycle; in_ready rises the following cycle.
- Latency: accept at edge E0, result visible after edge E_WIDTH (out_valid high starting in cycle WIDTH+1). Throughput is one operation per WIDTH+2 cycles when out_ready is held high.
- in_valid during RUN/DONE is ignored. Input values are sampled only at the accept edge; later changes have no effect.
- Reset asserted mid-RUN or mid-DONE: the operation is discarded with no partial out_valid, and the block returns to IDLE.
- Arithmetic is modulo 2^WIDTH.
  - Add: carry-out is bit WIDTH of A+B.
  - Subtract: computed as A + ~B + 1; out_carry=1 means A >= B unsigned.
- out_sum holds its last value in IDLE. Only out_valid qualifies it.

Decomposition:
- Shared package serial_add_pkg:
  - state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - op constants OP_ADD=1'b0, OP_SUB=1'b1
- One natural sub-module: sa_bit_cell, a combinational one-bit full-adder slice (a, b, cin -> s, cout), instantiated once.
- The FSM, shift registers, counter and flag logic live in serial_add_ctrl.

Test Plan:
- WIDTH=8, A=0x3C, B=0x05, add, out_ready=1 -> out_sum=0x41, out_carry=0, out_ovf=0; out_valid high exactly 9 cycles after accept.
- A=0xFF, B=0x01, add -> out_sum=0x00, out_carry=1, out_ovf=0.
- A=0x7F, B=0x01, add -> out_sum=0x80, out_carry=0, out_ovf=1. Then A=0x80, B=0x01, sub -> out_sum=0x7F, out_carry=1, out_ovf=1.
- A=0x05, B=0x07, sub -> out_sum=0xFE, out_carry=0 (borrow), out_ovf=0. A=0x07, B=0x05, sub -> 0x02, out_carry=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 and new operands -> outputs stable, in_ready=0, the new operands are not accepted. Release out_ready -> in_ready=1 the next cycle, then the new operation completes correctly.
- Pull rst_n low asynchronously mid-RUN (counter=3) -> out_valid=0 and in_ready=0 immediately; after release, in_ready=1 and a fresh 0x10+0x20 yields 0x30.
